// File: rtl/stereo_fm_ctrl.sv
// Stereo FM mux timing/config controller: 192/48 kHz clock enables, gain
// shadow/commit registers, and STOP -> FLUSH -> RUN start-up sequencing.
module stereo_fm_ctrl #(
  parameter int DIV192      = 256,
  parameter int FLUSH_TICKS = 64,
  parameter int FLUSH_W     = 7
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       run,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [2:0] cfg_addr,
  input  logic [7:0] cfg_data,
  output logic [3:0] Ks,
  output logic [3:0] Kd,
  output logic [3:0] Kp,
  output logic [7:0] Kf,
  output logic       clken48kHz,
  output logic       clken192kHz,
  output logic       mute,
  output logic       pending
);

  localparam int CNT_W = (DIV192 > 2) ? $clog2(DIV192) : 1;

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  typedef struct packed {
    logic [3:0] ks;
    logic [3:0] kd;
    logic [3:0] kp;
    logic [7:0] kf;
  } gains_t;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         phase_q, phase_d;
  logic               clken192_q, clken192_d;
  logic               clken48_q, clken48_d;
  logic [FLUSH_W-1:0] flush_q, flush_d;
  logic               pending_q, pending_d;
  gains_t             shadow_q, shadow_d;
  gains_t             active_q, active_d;

  logic               active;
  logic               tick;
  logic               xfer;
  logic               commit_req;
  logic               load;
  logic [FLUSH_W-1:0] flush_inc;

  assign cfg_ready   = !pending_q;
  assign pending     = pending_q;
  assign clken192kHz = clken192_q;
  assign clken48kHz  = clken48_q;
  assign mute        = (state_q != ST_RUN);
  assign Ks          = active_q.ks;
  assign Kd          = active_q.kd;
  assign Kp          = active_q.kp;
  assign Kf          = active_q.kf;

  // Prescaler and enables; a falling run stops new pulses from being registered.
  always_comb begin
    active     = (state_q != ST_STOP);
    tick       = active && run && (cnt_q == CNT_W'(DIV192 - 1));
    cnt_d      = cnt_q;
    phase_d    = phase_q;
    clken192_d = tick;
    clken48_d  = tick && (phase_q == 2'd3);
    if (!active || !run) begin
      cnt_d   = '0;
      phase_d = '0;
    end else if (tick) begin
      cnt_d   = '0;
      phase_d = phase_q + 2'd1;
    end else begin
      cnt_d   = cnt_q + CNT_W'(1);
    end
  end

  // Sequencer
  always_comb begin
    state_d   = state_q;
    flush_d   = flush_q;
    flush_inc = flush_q + FLUSH_W'(1);
    case (state_q)
      ST_STOP: begin
        if (run) begin
          state_d = ST_FLUSH;
          flush_d = '0;
        end
      end
      ST_FLUSH: begin
        if (clken48_q) begin
          flush_d = flush_inc;
          if (flush_inc == FLUSH_W'(FLUSH_TICKS)) state_d = ST_RUN;
        end
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_STOP;
    endcase
    if (!run) state_d = ST_STOP;
  end

  // Config port and commit. Gains move only on a 48 kHz boundary while the
  // enables run; when stopped (or stopping) there is no boundary to wait for.
  always_comb begin
    shadow_d   = shadow_q;
    active_d   = active_q;
    pending_d  = pending_q;
    xfer       = cfg_valid && cfg_ready;
    commit_req = 1'b0;
    load       = 1'b0;
    if (xfer) begin
      case (cfg_addr)
        3'd0:    shadow_d.ks = cfg_data[3:0];
        3'd1:    shadow_d.kd = cfg_data[3:0];
        3'd2:    shadow_d.kp = cfg_data[3:0];
        3'd3:    shadow_d.kf = cfg_data;
        3'd4:    commit_req  = 1'b1;
        default: commit_req  = 1'b0;
      endcase
    end
    if (pending_q && (!active || !run || clken48_q)) begin
      load      = 1'b1;
      pending_d = 1'b0;
    end
    if (commit_req) begin
      if (!active) load = 1'b1;
      else         pending_d = 1'b1;
    end
    if (load) active_d = shadow_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_STOP;
      cnt_q      <= '0;
      phase_q    <= '0;
      clken192_q <= 1'b0;
      clken48_q  <= 1'b0;
      flush_q    <= '0;
      pending_q  <= 1'b0;
      shadow_q   <= '0;
      active_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
      clken192_q <= clken192_d;
      clken48_q  <= clken48_d;
      flush_q    <= flush_d;
      pending_q  <= pending_d;
      shadow_q   <= shadow_d;
      active_q   <= active_d;
    end
  end

endmodule

// File: tb/tb_stereo_fm_ctrl.sv
// Directed bench for stereo_fm_ctrl: enable cadence, start-up muting, and
// gain commits checked against a queue of expected (gains, visible-cycle).
module tb_stereo_fm_ctrl;
  localparam int DIV = 4;
  localparam int FT  = 3;
  localparam int FW  = 7;

  logic       clock = 1'b0;
  logic       reset, run, cfg_valid, cfg_ready;
  logic [2:0] cfg_addr;
  logic [7:0] cfg_data;
  logic [3:0] Ks, Kd, Kp;
  logic [7:0] Kf;
  logic       clken48kHz, clken192kHz, mute, pending;
  logic [19:0] g_obs;

  assign g_obs = {Ks, Kd, Kp, Kf};

  stereo_fm_ctrl #(.DIV192(DIV), .FLUSH_TICKS(FT), .FLUSH_W(FW)) dut (
    .clock(clock), .reset(reset), .run(run),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .Ks(Ks), .Kd(Kd), .Kp(Kp), .Kf(Kf),
    .clken48kHz(clken48kHz), .clken192kHz(clken192kHz), .mute(mute), .pending(pending)
  );

  always #5 clock = ~clock;

  int nvec = 0;
  int nerr = 0;
  int k    = 0;

  typedef struct {
    logic [19:0] g;
    int          v;
  } exp_t;
  exp_t sb[$];

  task automatic step();
    @(posedge clock);
    #1;
    k++;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(logic [19:0] g, int v);
    exp_t e;
    e.g = g;
    e.v = v;
    sb.push_back(e);
  endtask

  task automatic pop_chk(string tag);
    exp_t e;
    e = sb.pop_front();
    chk({tag, "_gains"}, g_obs, e.g);
    chk({tag, "_cycle"}, k, e.v);
  endtask

  // Step until pending drops; gains must hold and writes stay stalled meanwhile.
  task automatic await_apply(string tag, logic [19:0] prev);
    bit done = 1'b0;
    for (int i = 0; i < 64 && !done; i++) begin
      step();
      if (pending === 1'b0) done = 1'b1;
      else begin
        chk({tag, "_hold"}, g_obs, prev);
        chk({tag, "_rdy"}, cfg_ready, 0);
      end
    end
    chk({tag, "_done"}, done, 1);
    pop_chk(tag);
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; cfg_valid = 1'b0; cfg_addr = '0; cfg_data = '0;
    step(); step();
    chk("rst_c192", clken192kHz, 0);
    chk("rst_c48", clken48kHz, 0);
    chk("rst_mute", mute, 1);
    chk("rst_pend", pending, 0);
    chk("rst_rdy", cfg_ready, 1);
    chk("rst_gains", g_obs, 0);
    reset = 1'b0;
    step();
    chk("stop_c192", clken192kHz, 0);
    chk("stop_mute", mute, 1);

    // Start-up: k counts cycles since FLUSH entry
    run = 1'b1;
    k = -1;
    for (int i = 0; i < 60; i++) begin
      step();
      chk("c192", clken192kHz, (k > 0 && k % 4 == 0));
      chk("c48", clken48kHz, (k > 0 && k % 16 == 0));
      chk("mute", mute, (k < 49));
    end

    // RUN commit: Ks (upper data bits dropped), Kf, commit at 62 -> pulse 64
    step();
    cfg_valid = 1'b1; cfg_addr = 3'd0; cfg_data = 8'h35;
    chk("run_rdy", cfg_ready, 1);
    step();
    cfg_addr = 3'd3; cfg_data = 8'hA7;
    step();
    cfg_addr = 3'd4; cfg_data = 8'hFF;
    push({4'h5, 4'h0, 4'h0, 8'hA7}, 65);
    step();
    cfg_valid = 1'b0;
    chk("run_pend", pending, 1);
    await_apply("run_commit", 20'h0);
    chk("run_mute", mute, 0);

    // Commit on the 48 kHz cycle itself waits for the next pulse; held Kd write stalls
    step();
    cfg_valid = 1'b1; cfg_addr = 3'd2; cfg_data = 8'h03;
    step();
    cfg_valid = 1'b0;
    while (k < 80) step();
    chk("c48_at_commit", clken48kHz, 1);
    cfg_valid = 1'b1; cfg_addr = 3'd4;
    push({4'h5, 4'h0, 4'h3, 8'hA7}, 97);
    step();
    cfg_addr = 3'd1; cfg_data = 8'h6C;
    chk("c48c_pend", pending, 1);
    await_apply("c48_commit", {4'h5, 4'h0, 4'h0, 8'hA7});
    chk("kd_rdy_after", cfg_ready, 1);
    step();
    cfg_addr = 3'd4;
    chk("kd_shadow_only", Kd, 0);
    push({4'h5, 4'hC, 4'h3, 8'hA7}, 113);
    step();
    cfg_valid = 1'b0;
    await_apply("kd_commit", {4'h5, 4'h0, 4'h3, 8'hA7});

    // Drop run: enables cease, muted
    run = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("off_c192", clken192kHz, 0);
      chk("off_c48", clken48kHz, 0);
      chk("off_mute", mute, 1);
    end

    // STOP commit applies immediately; Kp truncates 0x1F
    cfg_valid = 1'b1; cfg_addr = 3'd2; cfg_data = 8'h1F;
    step();
    cfg_addr = 3'd4;
    push({4'h5, 4'hC, 4'hF, 8'hA7}, k + 1);
    step();
    cfg_valid = 1'b0;
    chk("stop_pend", pending, 0);
    pop_chk("stop_commit");

    // Reserved address has no effect, even after a commit
    cfg_valid = 1'b1; cfg_addr = 3'd6; cfg_data = 8'hFF;
    step();
    cfg_valid = 1'b0;
    chk("a6_rdy", cfg_ready, 1);
    step();
    chk("a6_gains", g_obs, {4'h5, 4'hC, 4'hF, 8'hA7});
    cfg_valid = 1'b1; cfg_addr = 3'd4;
    push({4'h5, 4'hC, 4'hF, 8'hA7}, k + 1);
    step();
    cfg_valid = 1'b0;
    pop_chk("a6_commit");

    // Reset during FLUSH with a commit outstanding
    run = 1'b1;
    step();
    step();
    cfg_valid = 1'b1; cfg_addr = 3'd0; cfg_data = 8'h07;
    step();
    cfg_addr = 3'd4;
    step();
    cfg_valid = 1'b0;
    chk("fl_pend", pending, 1);
    reset = 1'b1;
    step();
    chk("mr_gains", g_obs, 0);
    chk("mr_pend", pending, 0);
    chk("mr_mute", mute, 1);
    chk("mr_c192", clken192kHz, 0);
    chk("mr_c48", clken48kHz, 0);
    chk("mr_rdy", cfg_ready, 1);
    reset = 1'b0;
    k = -1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("mr_restart_c192", clken192kHz, (k == 4));
      chk("mr_restart_mute", mute, 1);
    end
    run = 1'b0;
    step();
    cfg_valid = 1'b1; cfg_addr = 3'd4;
    push(20'h0, k + 1);
    step();
    cfg_valid = 1'b0;
    pop_chk("mr_shadow_cleared");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/stereo_fm_ctrl.md
Name: stereo_fm_ctrl

Overview:
Timing and configuration controller for the stereo FM multiplexer datapath. Divides the master clock into the 192 kHz and 48 kHz clock-enable pulses, with every 48 kHz pulse coincident with a 192 kHz pulse. Holds the Ks/Kd/Kp/Kf gain registers behind a valid/ready config port and applies committed gain changes only on a 48 kHz sample boundary. Sequences start-up through STOP -> FLUSH -> RUN and drives a mute flag while the encoder/interpolator pipeline settles.

Parameters:
DIV192, 256, master clock cycles per 192 kHz enable (49.152 MHz / 256); minimum 2
FLUSH_TICKS, 64, number of 48 kHz ticks held muted after start; minimum 1
FLUSH_W, 7, flush counter width; must hold FLUSH_TICKS

Ports:
clock  in  1  master clock, posedge
reset  in  1  synchronous, active-high reset
run  in  1  1 = generate enables; 0 = stop
cfg_valid  in  1  config write request
cfg_ready  out  1  config write accept
cfg_addr  in  3  0=Ks, 1=Kd, 2=Kp, 3=Kf, 4=commit, 5-7 reserved
cfg_data  in  8  write data; Ks/Kd/Kp use [3:0]
Ks  out  4  active gain
Kd  out  4  active gain
Kp  out  4  active gain
Kf  out  8  active gain
clken48kHz  out  1  one-cycle enable pulse, 48 kHz
clken192kHz  out  1  one-cycle enable pulse, 192 kHz
mute  out  1  1 = downstream must zero FMout
pending  out  1  commit accepted, not yet applied

Behaviour:
- Reset:
  - Outputs: all enables 0, mute=1, pending=0, cfg_ready=1; active and shadow gains all 0.
  - Internals: prescaler cnt=0, phase=0, flush counter=0, state=STOP.
- Prescaler and enables:
  - In FLUSH or RUN, cnt counts 0..DIV192-1 and wraps.
  - clken192kHz is registered. It is 1 for exactly the one cycle following the cycle where cnt==DIV192-1.
  - phase (2 bits) increments on each 192 kHz tick.
  - clken48kHz is 1 in the same cycle as clken192kHz when the pre-increment phase==3. The enables are therefore exactly aligned, 4:1.
  - In STOP, cnt and phase are held at 0 and both enables stay 0.
- FSM:
  - STOP: mute=1. When run=1, go to FLUSH and clear the flush counter.
  - FLUSH: mute=1. The flush counter increments on each clken48kHz. In the cycle where the counter reaches FLUSH_TICKS, go to RUN.
  - RUN: mute=0.
  - run=0 in any state: go to STOP next cycle; cnt and phase clear. An enable pulse already registered in that cycle still completes.
  - The first clken192kHz after STOP->FLUSH arrives DIV192 cycles after the transition.
- Config port:
  - A transfer occurs when cfg_valid & cfg_ready.
  - Addr 0-3 write the shadow register, truncating the data to the register width.
  - Addr 4 sets pending; cfg_data is ignored.
  - Addr 5-7 are accepted with no effect.
  - cfg_ready = !pending. While a commit is outstanding, all writes are stalled; cfg_valid must be held by the requester.
- Commit:
  - In FLUSH/RUN, the active gains load from shadow on the edge that ends a cycle with clken48kHz=1, and pending clears on the same edge. New gains are therefore visible from the cycle after the 48 kHz pulse and stay stable for a whole input sample.
  - Commit accepted in the same cycle as clken48kHz: the gains do not apply on that edge; they apply at the next 48 kHz pulse.
  - In STOP, the commit applies on the cycle after acceptance.
  - If run falls while pending, the commit applies on the first cycle in STOP.
- Shadow writes never alter the active gains without a commit.
- Reset mid-operation overrides everything: return to reset values next edge, discarding pending and shadow contents.

Test Plan:
- DIV192=4, reset then run=1 -> clken192kHz every 4 cycles, first pulse 4 cycles after FLUSH entry; clken48kHz every 16 cycles, always coincident with a 192 pulse; never two consecutive high cycles.
- FLUSH_TICKS=3, run=1 -> mute=1 through the 3rd clken48kHz; RUN and mute=0 from the next cycle; drop run -> STOP, enables cease, mute=1 next cycle.
- In RUN, write Ks=0x5, Kf=0xA7, then commit -> outputs unchanged until the 48 kHz pulse; Ks=5, Kf=0xA7 the cycle after; pending 1->0 on the same edge.
- Commit issued in the same cycle as clken48kHz -> applied at the following pulse, 16 cycles later; cfg_ready=0 throughout, and a held write to Kd is accepted only after pending clears.
- In STOP, write Kp=0x1F then commit -> Kp=0xF the cycle after the commit; addr 6 write leaves all gains unchanged.
- Assert reset during FLUSH with a commit pending -> all gains 0, pending=0, mute=1, enables 0, state STOP on the next cycle.
